// File: rtl/alu_hs.sv
// Handshaked signed ALU: single-cycle arithmetic/logic ops, an iterative
// shift-add multiply and a persistent accumulator behind valid/ready channels.
module alu_hs #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_oper,
  input  logic [WIDTH-1:0] i_arg0,
  input  logic [WIDTH-1:0] i_arg1,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flag
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [2:0] {
    OP_SUB   = 3'b000,
    OP_NAND  = 3'b001,
    OP_SONES = 3'b010,
    OP_OHDEC = 3'b011,
    OP_ADD   = 3'b100,
    OP_MUL   = 3'b101,
    OP_ACC   = 3'b110,
    OP_CLR   = 3'b111
  } op_t;

  localparam int                 MSB         = WIDTH - 1;
  localparam logic [CNT_W-1:0]   LAST_ITER   = CNT_W'(WIDTH - 1);
  localparam logic [2*WIDTH-1:0] MAX_POS     = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [2*WIDTH-1:0] MAX_NEG_MAG = MAX_POS + (2*WIDTH)'(1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         flag_q, flag_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               neg_q, neg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  op_t                op;
  logic               accept;
  logic [WIDTH-1:0]   sum, diff, acc_sum;
  logic               ones_run;
  logic [CNT_W-1:0]   ones_cnt, hot_cnt;
  logic [WIDTH-1:0]   hot_idx;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_err, sc_ovf;
  logic [WIDTH:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_nxt;
  logic               mul_ovf;
  logic [WIDTH-1:0]   mul_low;

  function automatic logic [3:0] mk_flag(input logic [WIDTH-1:0] r,
                                         input logic err, input logic ovf);
    logic nz;
    nz = |r;
    return {ovf, ~r[MSB] & nz, r[MSB] & nz, err};
  endfunction

  assign op      = op_t'(i_oper);
  assign o_ready = i_rstn && (state_q == S_IDLE || (state_q == S_DONE && i_ready));
  assign accept  = i_valid && o_ready;
  assign o_valid = (state_q == S_DONE);
  assign o_result = result_q;
  assign o_flag   = flag_q;

  // Single-cycle op results, evaluated directly on the operands being accepted.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sum      = i_arg0 + i_arg1;
    diff     = i_arg0 - i_arg1;
    acc_sum  = acc_q + i_arg0;
    ones_run = 1'b1;
    ones_cnt = '0;
    hot_cnt  = '0;
    hot_idx  = '0;
    sc_res   = '0;
    sc_err   = 1'b0;
    sc_ovf   = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (ones_run && i_arg0[i]) ones_cnt = ones_cnt + CNT_W'(1);
      else                       ones_run = 1'b0;
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (i_arg0[i]) begin
        hot_cnt = hot_cnt + CNT_W'(1);
        hot_idx = WIDTH'(i);
      end
    end
    case (op)
      OP_SUB: begin
        sc_res = diff;
        sc_ovf = (i_arg0[MSB] != i_arg1[MSB]) && (diff[MSB] != i_arg0[MSB]);
      end
      OP_NAND:  sc_res = ~(i_arg0 & i_arg1);
      OP_SONES: sc_res = WIDTH'(ones_cnt);
      OP_OHDEC: begin
        if (hot_cnt == CNT_W'(1)) sc_res = hot_idx;
        else                      sc_err = 1'b1;
      end
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (i_arg0[MSB] == i_arg1[MSB]) && (sum[MSB] != i_arg0[MSB]);
      end
      OP_MUL:   sc_res = '0;
      OP_ACC: begin
        sc_res = acc_sum;
        sc_ovf = (acc_q[MSB] == i_arg0[MSB]) && (acc_sum[MSB] != acc_q[MSB]);
      end
      OP_CLR:   sc_res = '0;
    endcase
  end

  // Multiply datapath: magnitudes are WIDTH+1 bits so the most negative
  // operand has a representable absolute value.
  always_comb begin
    mag_a    = i_arg0[MSB] ? ({1'b0, ~i_arg0} + (WIDTH+1)'(1)) : {1'b0, i_arg0};
    mag_b    = i_arg1[MSB] ? ({1'b0, ~i_arg1} + (WIDTH+1)'(1)) : {1'b0, i_arg1};
    prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);
    mul_ovf  = neg_q ? (prod_nxt > MAX_NEG_MAG) : (prod_nxt > MAX_POS);
    mul_low  = neg_q ? (~prod_nxt[MSB:0] + WIDTH'(1)) : prod_nxt[MSB:0];
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flag_d   = flag_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_BUSY: begin
        prod_d   = prod_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d  = S_DONE;
          result_d = mul_low;
          flag_d   = mk_flag(mul_low, 1'b0, mul_ovf);
        end
      end
      S_DONE: begin
        if (i_ready && !i_valid) state_d = S_IDLE;
      end
      S_IDLE: ;
      default: state_d = S_IDLE;
    endcase

    // accept is only possible from IDLE or from DONE with i_ready high.
    if (accept) begin
      if (op == OP_MUL) begin
        state_d  = S_BUSY;
        mcand_d  = {{(WIDTH-1){1'b0}}, mag_a};
        mplier_d = mag_b;
        prod_d   = '0;
        neg_d    = i_arg0[MSB] ^ i_arg1[MSB];
        cnt_d    = '0;
      end else begin
        state_d  = S_DONE;
        result_d = sc_res;
        flag_d   = mk_flag(sc_res, sc_err, sc_ovf);
        if (op == OP_ACC) acc_d = acc_sum;
        if (op == OP_CLR) acc_d = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      flag_q   <= '0;
      acc_q    <= '0;
      // NOTE: the multiply registers are reset as well, so an aborted multiply
      // leaves no stale partial product behind.
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_hs.sv
// Directed testbench for alu_hs at WIDTH=8: per-feature tasks with
// hand-computed expected results and flags.
module tb_alu_hs;

  localparam logic [2:0] SUB = 3'b000, NAND = 3'b001, SONES = 3'b010, OHDEC = 3'b011;
  localparam logic [2:0] ADD = 3'b100, MUL = 3'b101, ACC = 3'b110, CLR = 3'b111;

  logic       i_clk = 1'b0;
  logic       i_rstn, i_valid, o_ready, o_valid, i_ready;
  logic [2:0] i_oper;
  logic [7:0] i_arg0, i_arg1, o_result;
  logic [3:0] o_flag;
  int         n_cmp = 0;
  int         n_err = 0;

  alu_hs #(.WIDTH(8)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .o_ready(o_ready),
    .i_oper(i_oper), .i_arg0(i_arg0), .i_arg1(i_arg1), .o_valid(o_valid),
    .i_ready(i_ready), .o_result(o_result), .o_flag(o_flag)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_ready(input string nm, output logic ok);
    int waited = 0;
    while (o_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    ok = (o_ready === 1'b1);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s accept: o_ready=%b never rose, required 1", nm, o_ready);
    end
  endtask

  task automatic run_single(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] er, input logic [3:0] ef, input string nm);
    logic ok;
    i_valid = 1'b1; i_oper = op; i_arg0 = a; i_arg1 = b;
    wait_ready(nm, ok);
    if (!ok) begin
      i_valid = 1'b0;
      return;
    end
    tick();
    i_valid = 1'b0; i_oper = NAND; i_arg0 = 8'hA5; i_arg1 = 8'h5A;
    n_cmp++;
    if ({o_valid, o_result, o_flag} !== {1'b1, er, ef}) begin
      n_err++;
      $display("FAIL %s: valid=%b result=%h flag=%b, required valid=1 result=%h flag=%b",
               nm, o_valid, o_result, o_flag, er, ef);
    end
  endtask

  task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] er, input logic [3:0] ef, input string nm);
    logic ok;
    i_valid = 1'b1; i_oper = MUL; i_arg0 = a; i_arg1 = b;
    wait_ready(nm, ok);
    if (!ok) begin
      i_valid = 1'b0;
      return;
    end
    tick();
    // operands change while the multiply runs; the captured ones must be used
    i_valid = 1'b0; i_oper = SUB; i_arg0 = 8'h55; i_arg1 = 8'h33;
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if ({o_ready, o_valid} !== 2'b00) begin
        n_err++;
        $display("FAIL %s busy cycle %0d: ready=%b valid=%b, required 0 0", nm, k, o_ready, o_valid);
      end
      tick();
    end
    n_cmp++;
    if ({o_valid, o_result, o_flag} !== {1'b1, er, ef}) begin
      n_err++;
      $display("FAIL %s: valid=%b result=%h flag=%b, required valid=1 result=%h flag=%b",
               nm, o_valid, o_result, o_flag, er, ef);
    end
    tick();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge i_clk);
    #1;
    n_cmp++;
    if ({o_valid, o_result, o_flag, o_ready} !== 14'd0) begin
      n_err++;
      $display("FAIL reset_state: valid=%b result=%h flag=%b ready=%b, required all 0",
               o_valid, o_result, o_flag, o_ready);
    end
    i_rstn = 1'b1;
    i_ready = 1'b1;
    #1;
    n_cmp++;
    if ({o_ready, o_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_release: ready=%b valid=%b, required 1 0", o_ready, o_valid);
    end
  endtask

  task automatic test_back_to_back();
    run_single(SUB, 8'h80, 8'h01, 8'h7F, 4'b1100, "sub_min_minus_1");
    n_cmp++;
    if (o_ready !== 1'b1) begin
      n_err++;
      $display("FAIL done_ready: o_ready=%b, required 1", o_ready);
    end
    run_single(NAND, 8'h0F, 8'hFF, 8'hF0, 4'b0010, "nand");
    run_single(ADD, 8'd100, 8'd100, 8'hC8, 4'b1010, "add_ovf");
    run_single(ADD, 8'h7F, 8'h81, 8'h00, 4'b0000, "add_zero");
    run_single(SUB, 8'd5, 8'd5, 8'h00, 4'b0000, "sub_zero");
    run_single(SUB, 8'h7F, 8'hFF, 8'h80, 4'b1010, "sub_ovf");
    tick();
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_to_idle: o_valid=%b, required 0", o_valid);
    end
  endtask

  task automatic test_mul();
    run_mul(8'd12, 8'hF5, 8'h7C, 4'b1100, "mul_12_m11");
    run_mul(8'h80, 8'hFF, 8'h80, 4'b1010, "mul_min_m1");
    run_mul(8'hF9, 8'd9, 8'hC1, 4'b0010, "mul_m7_9");
    run_mul(8'h00, 8'hFB, 8'h00, 4'b0000, "mul_0_m5");
  endtask

  task automatic test_bitops();
    run_single(OHDEC, 8'h20, 8'h00, 8'd5, 4'b0100, "ohdec_0x20");
    run_single(OHDEC, 8'h24, 8'h00, 8'd0, 4'b0001, "ohdec_two_bits");
    run_single(OHDEC, 8'h00, 8'h00, 8'd0, 4'b0001, "ohdec_zero");
    run_single(OHDEC, 8'h80, 8'h00, 8'd7, 4'b0100, "ohdec_msb");
    run_single(SONES, 8'hE3, 8'h00, 8'd3, 4'b0100, "sones_0xe3");
    run_single(SONES, 8'hFF, 8'h00, 8'd8, 4'b0100, "sones_all");
    run_single(SONES, 8'h7F, 8'h00, 8'd0, 4'b0000, "sones_none");
  endtask

  task automatic test_acc();
    run_single(CLR, 8'h33, 8'h44, 8'd0, 4'b0000, "clr");
    run_single(ACC, 8'd100, 8'h00, 8'd100, 4'b0100, "acc_100");
    run_single(ACC, 8'd100, 8'h00, 8'hC8, 4'b1010, "acc_wrap");
    run_single(ADD, 8'd1, 8'd2, 8'd3, 4'b0100, "add_between");
    run_single(ACC, 8'd0, 8'h00, 8'hC8, 4'b0010, "acc_persist");
    tick();
  endtask

  task automatic test_backpressure();
    run_single(ADD, 8'd3, 8'd4, 8'd7, 4'b0100, "bp_add");
    i_ready = 1'b0;
    i_valid = 1'b1; i_oper = NAND; i_arg0 = 8'h0F; i_arg1 = 8'h0F;
    #1;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if ({o_valid, o_result, o_flag, o_ready} !== {1'b1, 8'd7, 4'b0100, 1'b0}) begin
        n_err++;
        $display("FAIL bp_hold cycle %0d: valid=%b result=%h flag=%b ready=%b, required 1 07 0100 0",
                 k, o_valid, o_result, o_flag, o_ready);
      end
      tick();
    end
    i_ready = 1'b1;
    #1;
    n_cmp++;
    if ({o_ready, o_valid, o_result} !== {1'b1, 1'b1, 8'd7}) begin
      n_err++;
      $display("FAIL bp_release: ready=%b valid=%b result=%h, required 1 1 07", o_ready, o_valid, o_result);
    end
    tick();
    i_valid = 1'b0;
    n_cmp++;
    if ({o_valid, o_result, o_flag} !== {1'b1, 8'hF0, 4'b0010}) begin
      n_err++;
      $display("FAIL bp_pending: valid=%b result=%h flag=%b, required 1 f0 0010", o_valid, o_result, o_flag);
    end
  endtask

  task automatic test_reset_mid_mul();
    logic ok;
    i_valid = 1'b1; i_oper = MUL; i_arg0 = 8'd12; i_arg1 = 8'hF5;
    wait_ready("rst_mul", ok);
    tick();
    i_valid = 1'b0;
    repeat (3) tick();
    #2 i_rstn = 1'b0;
    #1;
    n_cmp++;
    if ({o_valid, o_result, o_flag, o_ready} !== 14'd0) begin
      n_err++;
      $display("FAIL rst_async: valid=%b result=%h flag=%b ready=%b, required all 0",
               o_valid, o_result, o_flag, o_ready);
    end
    repeat (2) @(posedge i_clk);
    #1 i_rstn = 1'b1;
    #1;
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if ({o_valid, o_ready} !== 2'b01) begin
        n_err++;
        $display("FAIL rst_no_result cycle %0d: valid=%b ready=%b, required 0 1", k, o_valid, o_ready);
      end
      tick();
    end
    run_single(ADD, 8'd1, 8'd1, 8'd2, 4'b0100, "rst_add_1_1");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rstn = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_oper = 3'b000; i_arg0 = '0; i_arg1 = '0;
    test_reset();
    test_back_to_back();
    test_mul();
    test_bitops();
    test_acc();
    test_backpressure();
    test_reset_mid_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
